// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin/fixed-priority arbiter onto a single-strobe local bus
module bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1,
  parameter int RR     = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req,
  input  logic                m1_req,
  input  logic                m0_we,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m0_ack,
  output logic                m1_ack,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_rstrb,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          gnt,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  state_t state, state_nx;
  logic owner;
  logic we_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [3:0] cnt;
  logic start, pick1, rd_done;
  assign start = m0_req || m1_req;
  assign pick1 = m1_req && (!m0_req || (RR != 0 && !owner));
  assign rd_done = state == WAIT && cnt == 4'd0;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE  ? (start ? ISSUE : IDLE) :
               state == ISSUE ? (we_q ? ACK : WAIT) :
               state == WAIT  ? (cnt == 4'd0 ? ACK : WAIT) : IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      owner    <= 1'b1;
      we_q     <= 1'b0;
      wstrb_q  <= '0;
      s_addr   <= '0;
      s_wdata  <= '0;
      cnt      <= 4'd0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      if (state == IDLE && start) begin
        owner   <= pick1;
        we_q    <= pick1 ? m1_we : m0_we;
        wstrb_q <= pick1 ? m1_wstrb : m0_wstrb;
        s_addr  <= pick1 ? m1_addr : m0_addr;
        s_wdata <= pick1 ? m1_wdata : m0_wdata;
      end
      if (state == ISSUE && !we_q) cnt <= 4'(RD_LAT - 1);
      if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (rd_done && !owner) m0_rdata <= s_rdata;
      if (rd_done && owner) m1_rdata <= s_rdata;
    end
  always_comb begin
    s_wstrb = (state == ISSUE && we_q) ? wstrb_q : '0;
    s_rstrb = state == ISSUE && !we_q;
    m0_ack  = state == ACK && !owner;
    m1_ack  = state == ACK && owner;
    gnt     = state == IDLE ? 2'b00 : {owner, !owner};
    busy    = state != IDLE;
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed vector table plus multi-cycle sequences for bus_arbiter
module tb_bus_arbiter;
  localparam logic [31:0] A0 = 32'h0000_0010, A1 = 32'h4000_0004;
  localparam logic [31:0] W0 = 32'h1111_2222, W1 = 32'h0000_A5A5;
  localparam logic [31:0] DB = 32'hDEAD_BEEF;
  localparam logic [31:0] R1 = 32'h0101_0101, R2 = 32'h0202_0202;
  localparam logic [31:0] R3 = 32'h0303_0303, R4 = 32'h0404_0404;
  logic clk = 1'b0, rst = 1'b1;
  logic m0_req = 1'b0, m1_req = 1'b0, m0_we = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = A0, m1_addr = A1, m0_wdata = W0, m1_wdata = W1;
  logic [3:0] m0_wstrb = 4'hF, m1_wstrb = 4'b0011;
  logic [31:0] s_rdata = 32'h0;
  logic m0_ack [3], m1_ack [3], s_rstrb [3], busy [3];
  logic [31:0] m0_rdata [3], m1_rdata [3], s_addr [3], s_wdata [3];
  logic [3:0] s_wstrb [3];
  logic [1:0] gnt [3];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    bus_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(g == 1 ? 3 : 1), .RR(g == 2 ? 0 : 1)) u_dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
      .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
      .m0_wstrb(m0_wstrb), .m1_wstrb(m1_wstrb),
      .m0_ack(m0_ack[g]), .m1_ack(m1_ack[g]), .m0_rdata(m0_rdata[g]), .m1_rdata(m1_rdata[g]),
      .s_addr(s_addr[g]), .s_wdata(s_wdata[g]), .s_wstrb(s_wstrb[g]), .s_rstrb(s_rstrb[g]),
      .s_rdata(s_rdata), .gnt(gnt[g]), .busy(busy[g])
    );
  end
  typedef struct packed {
    logic [3:0] req;
    logic [3:0] ws0;
    logic [31:0] sr;
    logic [1:0] gnt;
    logic busy;
    logic rs;
    logic [3:0] ws;
    logic [1:0] ack;
    logic [31:0] sa, sw, rd0, rd1;
  } vec_t;
  vec_t vq [$];
  task automatic add(input logic [3:0] req, ws0, input logic [31:0] sr, input logic [1:0] g,
                     input logic b, rs, input logic [3:0] ws, input logic [1:0] ack,
                     input logic [31:0] sa, sw, rd0, rd1);
    vq.push_back({req, ws0, sr, g, b, rs, ws, ack, sa, sw, rd0, rd1});
  endtask
  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0d: got %0h, expected %0h", nm, idx, got, exp);
    end
  endtask
  task automatic chk_zero(input int k);
    chk("rst_gnt", k, 32'(gnt[k]), 32'h0);
    chk("rst_busy", k, 32'(busy[k]), 32'h0);
    chk("rst_m0_ack", k, 32'(m0_ack[k]), 32'h0);
    chk("rst_m1_ack", k, 32'(m1_ack[k]), 32'h0);
    chk("rst_m0_rdata", k, m0_rdata[k], 32'h0);
    chk("rst_m1_rdata", k, m1_rdata[k], 32'h0);
    chk("rst_s_addr", k, s_addr[k], 32'h0);
    chk("rst_s_wdata", k, s_wdata[k], 32'h0);
    chk("rst_s_wstrb", k, 32'(s_wstrb[k]), 32'h0);
    chk("rst_s_rstrb", k, 32'(s_rstrb[k]), 32'h0);
  endtask
  task automatic do_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk_zero(k);
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    vec_t v;
    int iss0, iss2, rr_a0, rr_a1, fp_a0, fp_a1;
    add(4'b1000, 4'hF, 32'h0, 2'b00, 1'b0, 1'b0, 4'h0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    add(4'b1000, 4'hF, 32'h0, 2'b01, 1'b1, 1'b1, 4'h0, 2'b00, A0, W0, 32'h0, 32'h0);
    add(4'b1000, 4'hF, DB,    2'b01, 1'b1, 1'b0, 4'h0, 2'b00, A0, W0, 32'h0, 32'h0);
    add(4'b1000, 4'hF, 32'h0, 2'b01, 1'b1, 1'b0, 4'h0, 2'b10, A0, W0, DB, 32'h0);
    add(4'b0000, 4'hF, 32'h0, 2'b00, 1'b0, 1'b0, 4'h0, 2'b00, A0, W0, DB, 32'h0);
    add(4'b0011, 4'hF, 32'h0, 2'b00, 1'b0, 1'b0, 4'h0, 2'b00, A0, W0, DB, 32'h0);
    add(4'b0011, 4'hF, 32'h0, 2'b10, 1'b1, 1'b0, 4'h3, 2'b00, A1, W1, DB, 32'h0);
    add(4'b0011, 4'hF, 32'h0, 2'b10, 1'b1, 1'b0, 4'h0, 2'b01, A1, W1, DB, 32'h0);
    add(4'b0000, 4'hF, 32'h0, 2'b00, 1'b0, 1'b0, 4'h0, 2'b00, A1, W1, DB, 32'h0);
    add(4'b1010, 4'hF, 32'h0, 2'b00, 1'b0, 1'b0, 4'h0, 2'b00, A1, W1, DB, 32'h0);
    add(4'b1010, 4'hF, 32'h0, 2'b01, 1'b1, 1'b1, 4'h0, 2'b00, A0, W0, DB, 32'h0);
    add(4'b1010, 4'hF, R1,    2'b01, 1'b1, 1'b0, 4'h0, 2'b00, A0, W0, DB, 32'h0);
    add(4'b1010, 4'hF, 32'h0, 2'b01, 1'b1, 1'b0, 4'h0, 2'b10, A0, W0, R1, 32'h0);
    add(4'b1010, 4'hF, 32'h0, 2'b00, 1'b0, 1'b0, 4'h0, 2'b00, A0, W0, R1, 32'h0);
    add(4'b1010, 4'hF, 32'h0, 2'b10, 1'b1, 1'b1, 4'h0, 2'b00, A1, W1, R1, 32'h0);
    add(4'b1010, 4'hF, R2,    2'b10, 1'b1, 1'b0, 4'h0, 2'b00, A1, W1, R1, 32'h0);
    add(4'b1010, 4'hF, 32'h0, 2'b10, 1'b1, 1'b0, 4'h0, 2'b01, A1, W1, R1, R2);
    add(4'b1010, 4'hF, 32'h0, 2'b00, 1'b0, 1'b0, 4'h0, 2'b00, A1, W1, R1, R2);
    add(4'b1010, 4'hF, 32'h0, 2'b01, 1'b1, 1'b1, 4'h0, 2'b00, A0, W0, R1, R2);
    add(4'b1010, 4'hF, R3,    2'b01, 1'b1, 1'b0, 4'h0, 2'b00, A0, W0, R1, R2);
    add(4'b1010, 4'hF, 32'h0, 2'b01, 1'b1, 1'b0, 4'h0, 2'b10, A0, W0, R3, R2);
    add(4'b1010, 4'hF, 32'h0, 2'b00, 1'b0, 1'b0, 4'h0, 2'b00, A0, W0, R3, R2);
    add(4'b1010, 4'hF, 32'h0, 2'b10, 1'b1, 1'b1, 4'h0, 2'b00, A1, W1, R3, R2);
    add(4'b1010, 4'hF, R4,    2'b10, 1'b1, 1'b0, 4'h0, 2'b00, A1, W1, R3, R2);
    add(4'b1010, 4'hF, 32'h0, 2'b10, 1'b1, 1'b0, 4'h0, 2'b01, A1, W1, R3, R4);
    add(4'b0000, 4'hF, 32'h0, 2'b00, 1'b0, 1'b0, 4'h0, 2'b00, A1, W1, R3, R4);
    add(4'b1100, 4'h0, 32'h0, 2'b00, 1'b0, 1'b0, 4'h0, 2'b00, A1, W1, R3, R4);
    add(4'b1100, 4'h0, 32'h0, 2'b01, 1'b1, 1'b0, 4'h0, 2'b00, A0, W0, R3, R4);
    add(4'b1100, 4'h0, 32'h0, 2'b01, 1'b1, 1'b0, 4'h0, 2'b10, A0, W0, R3, R4);
    add(4'b0000, 4'hF, 32'h0, 2'b00, 1'b0, 1'b0, 4'h0, 2'b00, A0, W0, R3, R4);
    do_reset;
    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      {m0_req, m0_we, m1_req, m1_we} = v.req;
      m0_wstrb = v.ws0;
      s_rdata = v.sr;
      chk("gnt", i, 32'(gnt[0]), 32'(v.gnt));
      chk("busy", i, 32'(busy[0]), 32'(v.busy));
      chk("s_rstrb", i, 32'(s_rstrb[0]), 32'(v.rs));
      chk("s_wstrb", i, 32'(s_wstrb[0]), 32'(v.ws));
      chk("acks", i, 32'({m0_ack[0], m1_ack[0]}), 32'(v.ack));
      chk("s_addr", i, s_addr[0], v.sa);
      chk("s_wdata", i, s_wdata[0], v.sw);
      chk("m0_rdata", i, m0_rdata[0], v.rd0);
      chk("m1_rdata", i, m1_rdata[0], v.rd1);
      @(posedge clk);
      #1;
    end
    {m0_req, m0_we, m1_req, m1_we} = 4'b0000;
    m0_wstrb = 4'hF;
    do_reset;
    {m0_req, m0_we, m1_req, m1_we} = 4'b1010;
    iss0 = 0; iss2 = 0; rr_a0 = 0; rr_a1 = 0; fp_a0 = 0; fp_a1 = 0;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk);
      #1;
      s_rdata = 32'(c);
      if (s_rstrb[0]) begin
        chk("rr_gnt", iss0, 32'(gnt[0]), iss0 % 2 == 0 ? 32'd1 : 32'd2);
        iss0++;
      end
      if (s_rstrb[2]) begin
        chk("fp_gnt", iss2, 32'(gnt[2]), 32'd1);
        iss2++;
      end
      if (m0_ack[0]) rr_a0++;
      if (m1_ack[0]) rr_a1++;
      if (m0_ack[2]) fp_a0++;
      if (m1_ack[2]) fp_a1++;
    end
    chk("rr_issues", 0, 32'(iss0), 32'd4);
    chk("rr_m0_acks", 0, 32'(rr_a0), 32'd2);
    chk("rr_m1_acks", 0, 32'(rr_a1), 32'd2);
    chk("fp_issues", 0, 32'(iss2), 32'd4);
    chk("fp_m0_acks", 0, 32'(fp_a0), 32'd4);
    chk("fp_m1_acks", 0, 32'(fp_a1), 32'd0);
    {m0_req, m0_we, m1_req, m1_we} = 4'b0000;
    do_reset;
    {m0_req, m0_we, m1_req, m1_we} = 4'b1000;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #1;
      s_rdata = 32'hAAAA_0000 | 32'(c);
      if (c == 6) m0_req = 1'b0;
      chk("l3_ack", c, 32'(m0_ack[1]), 32'(c == 5));
      chk("l3_busy", c, 32'(busy[1]), 32'(c <= 5));
      chk("l3_rstrb", c, 32'(s_rstrb[1]), 32'(c == 1));
      chk("l3_rdata", c, m0_rdata[1], c >= 5 ? 32'hAAAA_0004 : 32'h0);
      if (c <= 3) chk("l1_ack", c, 32'(m0_ack[0]), 32'(c == 3));
      if (c == 3) chk("l1_rdata", c, m0_rdata[0], 32'hAAAA_0002);
    end
    do_reset;
    {m0_req, m0_we, m1_req, m1_we} = 4'b1000;
    repeat (2) @(posedge clk);
    #1;
    chk("mw_pre_busy", 0, 32'(busy[1]), 32'd1);
    chk("mw_pre_addr", 0, s_addr[1], A0);
    #2;
    rst = 1'b1;
    {m0_req, m0_we, m1_req, m1_we} = 4'b0010;
    #1;
    for (int k = 0; k < 3; k++) chk_zero(k);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #1;
      if (c == 6) m1_req = 1'b0;
      chk("mw_m0_ack", c, 32'(m0_ack[1]), 32'd0);
      chk("mw_m1_ack", c, 32'(m1_ack[1]), 32'(c == 5));
      if (c == 1) chk("mw_gnt_l3", c, 32'(gnt[1]), 32'd2);
      if (c == 1) chk("mw_gnt_l1", c, 32'(gnt[0]), 32'd2);
    end
    do_reset;
    {m0_req, m0_we, m1_req, m1_we} = 4'b1010;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk("first_tie_gnt", k, 32'(gnt[k]), 32'd1);
    {m0_req, m0_we, m1_req, m1_we} = 4'b0000;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
